// File: rtl/aurora_tx_gearbox_if.sv
// Handshake bundle between the encoder lane output, the 66:32 TX gearbox and the lane serializer.
// master drives blocks in and accepts words; slave is the gearbox view.
interface aurora_tx_gearbox_if #(
    parameter int unsigned IN_WIDTH  = 66,
    parameter int unsigned OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aurora_tx_gearbox.sv
// Per-lane 66:32 TX gearbox: bit buffer, oldest bit at index 0, fed header-first per block.
// Optional underrun counter enabled by defining AURORA_GEARBOX_UNDERRUN_CNT_EN.
module aurora_tx_gearbox #(
    parameter int unsigned IN_WIDTH  = 66,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned BUF_WIDTH = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    aurora_tx_gearbox_if.slave             bus,
    output logic [$clog2(BUF_WIDTH+1)-1:0] fill_level
`ifdef AURORA_GEARBOX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                    underrun_cnt
`endif
);
    localparam int unsigned    CW        = $clog2(BUF_WIDTH + 1);
    localparam logic [CW-1:0] OUT_W     = CW'(OUT_WIDTH);
    localparam logic [CW-1:0] IN_W      = CW'(IN_WIDTH);
    localparam logic [CW-1:0] READY_MAX = CW'(BUF_WIDTH - IN_WIDTH);

    logic [BUF_WIDTH-1:0] buffer;
    logic [BUF_WIDTH-1:0] buffer_next;
    logic [BUF_WIDTH-1:0] blk_ext;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic [CW-1:0]        shift;
    logic [CW-1:0]        base;
    logic                 in_fire;
    logic                 out_fire;

    assign bus.out_valid = (count >= OUT_W);
    assign bus.in_ready  = (count <= READY_MAX);
    assign bus.out_data  = buffer[OUT_WIDTH-1:0];
    assign fill_level    = count;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;

    // New block lands directly above the bits that survive this cycle's word drain.
    always_comb begin
        shift       = out_fire ? OUT_W : '0;
        base        = count - shift;
        blk_ext     = '0;
        blk_ext[IN_WIDTH-1:0] = {bus.in_data[IN_WIDTH-3:0], bus.in_data[IN_WIDTH-1:IN_WIDTH-2]};
        buffer_next = buffer >> shift;
        count_next  = base;
        if (in_fire) begin
            buffer_next = buffer_next | (blk_ext << base);
            count_next  = base + IN_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
            count  <= '0;
        end else begin
            buffer <= buffer_next;
            count  <= count_next;
        end
    end

`ifdef AURORA_GEARBOX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (bus.out_ready && !bus.out_valid && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_aurora_tx_gearbox.sv
// Scoreboard bench for aurora_tx_gearbox: driver pushes expected words, negedge monitor pops and compares.
// Define AURORA_GEARBOX_UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_aurora_tx_gearbox;
    logic       clk;
    logic       rst;
    logic [7:0] fill_level;
`ifdef AURORA_GEARBOX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    aurora_tx_gearbox_if #(.IN_WIDTH(66), .OUT_WIDTH(32)) bus ();

    aurora_tx_gearbox #(.IN_WIDTH(66), .OUT_WIDTH(32), .BUF_WIDTH(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fill_level   (fill_level)
`ifdef AURORA_GEARBOX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          word_cnt = 0;
    int          gap_cnt  = 0;
    bit          sb_en = 1'b0;
    logic [31:0] sb[$];
    bit          bitq[$];

    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (!rst && sb_en) begin
            if (bus.out_valid && bus.out_ready) begin
                word_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL word_unexpected act=%h exp=<none>", bus.out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (bus.out_data !== exp_w) begin
                        bad++;
                        $display("FAIL word act=%h exp=%h", bus.out_data, exp_w);
                    end
                end
            end else if (bus.out_ready && word_cnt > 0 && sb.size() > 0) begin
                gap_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
        end
    endtask

    // Reference serializer: header bit 64, bit 65, then payload bits 0..63.
    task automatic model_push(input logic [65:0] d);
        logic [31:0] w;
        bitq.push_back(d[64]);
        bitq.push_back(d[65]);
        for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
        while (bitq.size() >= 32) begin
            for (int j = 0; j < 32; j++) w[j] = bitq.pop_front();
            sb.push_back(w);
        end
    endtask

    task automatic send_block(input logic [65:0] d, input bit use_model);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (use_model) model_push(d);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL accept_timeout act=in_ready_low exp=accepted");
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        rst   = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        bitq.delete();
        rst   = 1'b0;
        sb_en = 1'b1;
    endtask

    initial begin
        logic [65:0] d;
        bit          hit;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;

        // 1: reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_fill", 64'(fill_level), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // 2: single block, hand-computed words
        bus.out_ready = 1'b1;
        sb.push_back(32'h26AF_37BD);
        sb.push_back(32'h048D_159E);
        send_block({2'b01, 64'h0123_4567_89AB_CDEF}, 1'b0);
        bus.in_valid = 1'b0;
        wait_drain("single_drain");
        @(negedge clk);
        check("single_out_valid", 64'(bus.out_valid), 64'd0);
        check("single_fill", 64'(fill_level), 64'd2);
        check("single_in_ready", 64'(bus.in_ready), 64'd1);

        // 3: 16 back-to-back blocks -> 33 continuous words
        do_reset();
        bus.out_ready = 1'b1;
        word_cnt = 0;
        gap_cnt  = 0;
        for (int b = 0; b < 16; b++) begin
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[65:64] = 2'($urandom_range(2, 1));
            send_block(d, 1'b1);
        end
        bus.in_valid = 1'b0;
        wait_drain("stream_drain");
        @(negedge clk);
        check("stream_words", 64'(word_cnt), 64'd33);
        check("stream_gaps", 64'(gap_cnt), 64'd0);
        check("stream_fill", 64'(fill_level), 64'd0);
        @(posedge clk); #1;

        // 4: backpressure holds first word, then resumes without loss
        do_reset();
        bus.out_ready = 1'b0;
        send_block({2'b10, 64'hFEDC_BA98_7654_3210}, 1'b1);
        bus.in_data = {2'b01, 64'h5A5A_0F0F_C3C3_9696};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_data", 64'(bus.out_data), 64'hD950_C842);
            check("hold_fill", 64'(fill_level), 64'd66);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_block({2'b01, 64'h5A5A_0F0F_C3C3_9696}, 1'b1);
        bus.in_valid = 1'b0;
        wait_drain("hold_drain");
        @(negedge clk);
        check("hold_left_fill", 64'(fill_level), 64'd4);
        @(posedge clk); #1;

        // 5: reset at fill_level 96
        do_reset();
        sb_en = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {2'b10, 64'hAAAA_5555_1234_8765};
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (fill_level == 8'd96) hit = 1'b1;
        end
        check("fill96_reached", 64'(hit), 64'd1);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_fill", 64'(fill_level), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk); #1;

`ifdef AURORA_GEARBOX_UNDERRUN_CNT_EN
        // 6: underrun counter and saturation
        bus.out_ready = 1'b1;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("underrun_10", 64'(underrun_cnt), 64'd10);
        repeat (70000) @(posedge clk);
        #1;
        check("underrun_sat", 64'(underrun_cnt), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
